// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: write port, two read ports and the clear handshake.
// master drives addresses/data/requests; slave (the register file) returns read data and status.
interface reg_file_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic [DATA_W-1:0] IN;
  logic [ADDR_W-1:0] INADDRESS;
  logic              WRITE;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              CLEAR;
  logic              BUSY;
  logic              WR_DROP;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
    input  OUT1, OUT2, BUSY, WR_DROP
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
    output OUT1, OUT2, BUSY, WR_DROP
  );
endinterface

// File: rtl/reg_file_param.sv
// DEPTH x DATA_W register file: two combinational read ports, one write port, sequenced CLEAR engine.
// Optional macro REGFILE_BYPASS_EN: write-first forwarding of IN onto read ports while IDLE.
module reg_file_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter bit          ZERO_REG0 = 1'b0
) (
  input logic              CLK,
  input logic              RESET,
  reg_file_param_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] regs [DEPTH];

  // Next-state and storage-write selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    drop_d   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = bus.INADDRESS;
    mem_data = bus.IN;
    unique case (state_q)
      IDLE: begin
        if (bus.WRITE && !(ZERO_REG0 && (bus.INADDRESS == '0))) mem_we = 1'b1;
        if (bus.CLEAR) begin
          state_d = CLEARING;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEARING: begin
        mem_we   = 1'b1;
        mem_addr = cnt_q;
        mem_data = '0;
        drop_d   = bus.WRITE;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (mem_we) begin
      regs[mem_addr] <= mem_data;
    end
  end

  // Read port 1; hardwired-zero register overrides forwarding
  always_comb begin
    bus.OUT1 = regs[bus.OUT1ADDRESS];
`ifdef REGFILE_BYPASS_EN
    if ((state_q == IDLE) && bus.WRITE && (bus.INADDRESS == bus.OUT1ADDRESS)) bus.OUT1 = bus.IN;
`endif
    if (ZERO_REG0 && (bus.OUT1ADDRESS == '0)) bus.OUT1 = '0;
  end

  // Read port 2
  always_comb begin
    bus.OUT2 = regs[bus.OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
    if ((state_q == IDLE) && bus.WRITE && (bus.INADDRESS == bus.OUT2ADDRESS)) bus.OUT2 = bus.IN;
`endif
    if (ZERO_REG0 && (bus.OUT2ADDRESS == '0)) bus.OUT2 = '0;
  end

  assign bus.BUSY    = busy_q;
  assign bus.WR_DROP = drop_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (ZERO_REG0 = 0 and 1) driven in lockstep and
// compared each cycle against an array-based model of the register file and clear sequence.
module tb_reg_file_param;

  logic CLK = 1'b0;
  logic RESET;
  always #10 CLK = ~CLK;

  logic [7:0] d_v;
  logic [2:0] wa_v, a1_v, a2_v;
  logic       wr_v, clr_v;

  reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
  reg_file_param_if #(.DATA_W(8), .ADDR_W(3)) bus1 ();

  assign bus0.IN = d_v;  assign bus0.INADDRESS = wa_v;  assign bus0.WRITE = wr_v;
  assign bus0.OUT1ADDRESS = a1_v;  assign bus0.OUT2ADDRESS = a2_v;  assign bus0.CLEAR = clr_v;
  assign bus1.IN = d_v;  assign bus1.INADDRESS = wa_v;  assign bus1.WRITE = wr_v;
  assign bus1.OUT1ADDRESS = a1_v;  assign bus1.OUT2ADDRESS = a2_v;  assign bus1.CLEAR = clr_v;

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG0(1'b0)) dut0 (.CLK(CLK), .RESET(RESET), .bus(bus0));
  reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG0(1'b1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents, clear progress and drop flag per instance
  logic [7:0] m [2][8];
  bit         mbusy [2];
  int         midx  [2];
  bit         mdrop [2];
  bit         z0    [2];

  function automatic logic [7:0] exp_rd(input int k, input logic [2:0] a);
    if (z0[k] && a == 3'd0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
    if (!mbusy[k] && wr_v && wa_v == a) return d_v;
`endif
    return m[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m[k][i] = 8'h00;
      mbusy[k] = 0; midx[k] = 0; mdrop[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (mbusy[k]) begin
        mdrop[k] = wr_v;
        m[k][midx[k]] = 8'h00;
        midx[k]++;
        if (midx[k] == 8) begin mbusy[k] = 0; midx[k] = 0; end
      end else begin
        mdrop[k] = 0;
        if (wr_v && !(z0[k] && wa_v == 3'd0)) m[k][wa_v] = d_v;
        if (clr_v) begin mbusy[k] = 1; midx[k] = 0; end
      end
    end
  endtask

  task automatic check_outputs();
    check("z0off_out1", 32'(bus0.OUT1), 32'(exp_rd(0, a1_v)));
    check("z0off_out2", 32'(bus0.OUT2), 32'(exp_rd(0, a2_v)));
    check("z0off_busy", 32'(bus0.BUSY), 32'(mbusy[0]));
    check("z0off_drop", 32'(bus0.WR_DROP), 32'(mdrop[0]));
    check("z0on_out1", 32'(bus1.OUT1), 32'(exp_rd(1, a1_v)));
    check("z0on_out2", 32'(bus1.OUT2), 32'(exp_rd(1, a2_v)));
    check("z0on_busy", 32'(bus1.BUSY), 32'(mbusy[1]));
    check("z0on_drop", 32'(bus1.WR_DROP), 32'(mdrop[1]));
  endtask

  // One clock cycle: drive after negedge, check before posedge, advance model at posedge
  task automatic cycle(input logic w, input logic [2:0] wa, input logic [7:0] d,
                       input logic c, input logic [2:0] r1, input logic [2:0] r2);
    @(negedge CLK);
    wr_v = w; wa_v = wa; d_v = d; clr_v = c; a1_v = r1; a2_v = r2;
    #1;
    check_outputs();
    @(posedge CLK);
    model_edge();
  endtask

  // Asynchronous reset pulse entirely between clock edges
  task automatic do_reset();
    @(negedge CLK);
    wr_v = 0; clr_v = 0;
    RESET = 1'b1;
    #1;
    model_reset();
    check("rst_busy_now", 32'(bus0.BUSY), 32'd0);
    for (int a = 0; a < 8; a++) begin
      a1_v = 3'(a); a2_v = 3'(7 - a);
      #1;
      check_outputs();
    end
    RESET = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 8'(i + 1), 1'b0, 3'(i), 3'(7 - i));
  endtask

  initial begin
    z0[0] = 0; z0[1] = 1;
    d_v = '0; wa_v = '0; a1_v = '0; a2_v = '0; wr_v = 0; clr_v = 0;
    RESET = 1'b1;
    model_reset();
    #5;
    check_outputs();
    RESET = 1'b0;

    // Write then read back on both ports
    cycle(1, 3'd3, 8'h5A, 0, 3'd0, 3'd0);
    cycle(1, 3'd7, 8'hC3, 0, 3'd0, 3'd0);
    cycle(0, 3'd0, 8'h00, 0, 3'd3, 3'd7);
    #1;
    check("rd_r3", 32'(bus0.OUT1), 32'h5A);
    check("rd_r7", 32'(bus0.OUT2), 32'hC3);
    cycle(0, 3'd0, 8'h00, 0, 3'd7, 3'd7);

    // Register 0 write on both builds, then forwarding probe on r5
    cycle(1, 3'd0, 8'h77, 0, 3'd0, 3'd0);
    cycle(0, 3'd0, 8'h00, 0, 3'd0, 3'd0);
    #1;
    check("r0_hardzero", 32'(bus1.OUT1), 32'h00);
    check("r0_normal", 32'(bus0.OUT1), 32'h77);
    cycle(1, 3'd5, 8'hAA, 0, 3'd5, 3'd0);
    cycle(0, 3'd0, 8'h00, 0, 3'd5, 3'd5);

    // Reset with populated storage
    fill();
    do_reset();

    // Full clear sequence with a dropped write mid-sequence
    fill();
    cycle(0, 3'd0, 8'h00, 1, 3'd0, 3'd1);
    for (int k = 0; k < 8; k++)
      cycle(k == 3, 3'd2, 8'hFF, k == 5, 3'(k), 3'd2);
    #1;
    check("clr_done_busy", 32'(bus0.BUSY), 32'd0);
    cycle(0, 3'd0, 8'h00, 0, 3'd2, 3'd7);

    // Back-to-back clear with CLEAR held high
    fill();
    for (int k = 0; k < 19; k++) cycle(0, 3'd0, 8'h00, 1, 3'(k), 3'(k + 3));

    // Reset during cycle 4 of a sequence, then a fresh sequence
    fill();
    cycle(0, 3'd0, 8'h00, 1, 3'd0, 3'd0);
    for (int k = 0; k < 3; k++) cycle(0, 3'd0, 8'h00, 0, 3'(k), 3'(k + 4));
    do_reset();
    fill();
    cycle(0, 3'd0, 8'h00, 1, 3'd0, 3'd0);
    for (int k = 0; k < 9; k++) cycle(0, 3'd0, 8'h00, 0, 3'(k), 3'(7 - k));

    // Random traffic
    for (int n = 0; n < 600; n++)
      cycle(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
            1'($urandom_range(0, 15) == 0), 3'($urandom), 3'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
